regdst_track: RTL and testbench
===============================

Name: regdst_track

Overview:
- Pipeline destination-register tracker for the pipelined CPU; the producing end of the forwarding path.
- Takes the 5-bit destination register number chosen in ID and carries it through EX/MEM/WB.
- Decodes the WB entry into a one-hot register-file write enable.
- Compares the ID source registers against in-flight destinations and generates the 2-bit select codes that drive the 4-to-1 operand forwarding muxes.

Parameters:
- REG_W, 5, register-number width.
- NREG, 32, register count; must equal 2**REG_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_we  input  1  instruction writes a register.
- id_dest  input  REG_W  destination register number, from the dest-select mux.
- stall  input  1  ID held this cycle; bubble inserted into EX.
- flush  input  1  ID instruction squashed; bubble inserted into EX.
- id_rs  input  REG_W  source A register number.
- id_rt  input  REG_W  source B register number.
- ex_dest, mem_dest, wb_dest  output  REG_W  registered destination per stage.
- ex_wr, mem_wr, wb_wr  output  1  stage holds a valid write to a nonzero register.
- wb_we_onehot  output  NREG  register-file write enable, bit n = write register n.
- busy_vec  output  NREG  OR of one-hot pending writes in EX, MEM and WB.
- fwd_sel_a  output  2  forwarding select for source A.
- fwd_sel_b  output  2  forwarding select for source B.

Behaviour:
- One clock; reset is synchronous and active-high on clk/rst.
- State: three stage registers {wr, dest}. No other state.
- Reset: every wr and dest = 0, so all outputs = 0 the cycle after rst is sampled high. Reset dominates stall and flush. Reset mid-operation discards all in-flight writes; no write enable is produced for them.
- Each rising edge with rst=0:
  - EX.wr <= id_valid & id_we & (id_dest!=0) & ~stall & ~flush.
  - EX.dest <= id_dest when that term is 1, else 0.
  - MEM <= EX; WB <= MEM.
  - MEM and WB always advance; stall does not freeze later stages.
- Latency: a write accepted at edge k appears in EX after k, MEM after k+1, WB after k+2. It drives wb_we_onehot for exactly one cycle.
- Register 0 is never written and never tracked. A dest of 0 behaves as we=0.
- wb_we_onehot: combinational decode of WB. Bit wb_dest set iff wb_wr, all other bits 0. At most one bit set.
- busy_vec: combinational, = decode(EX) | decode(MEM) | decode(WB).
- fwd_sel_x for source s (s = id_rs or id_rt):
  - 2'b00: s==0 or no match; use regfile.
  - 2'b01: ex_wr & ex_dest==s.
  - 2'b10: mem_wr & mem_dest==s.
  - 2'b11: wb_wr & wb_dest==s.
  - Priority on multiple match: EX > MEM > WB (youngest wins).
- fwd_sel is combinational from current stage registers and id_rs/id_rt, and is valid in the same cycle as the inputs.
- Simultaneous stall and flush: single bubble, same as either alone.
- No internal overflow or wrap conditions; widths fixed by REG_W.

Test Plan:
1. Reset: rst=1 for 2 cycles with id_valid=1, id_we=1, id_dest=9 -> all outputs 0; after release with id inputs idle, outputs stay 0.
2. Single write, id_dest=5, id_we=1 at edge 0, then idle; id_rs=5 held:
   - cycle 1: ex_dest=5, fwd_sel_a=01.
   - cycle 2: fwd_sel_a=10.
   - cycle 3: fwd_sel_a=11, wb_we_onehot=0x00000020.
   - cycle 4: fwd_sel_a=00, busy_vec=0.
3. Priority: writes to r7 on three consecutive edges, id_rt=7 -> fwd_sel_b=01 while EX holds r7; busy_vec=0x80 throughout the overlap.
4. Zero register: id_dest=0, id_we=1, id_rs=0 -> ex_wr=0, wb_we_onehot stays 0, fwd_sel_a=00.
5. Stall/flush: write r3 with stall=1 -> EX.wr=0. Repeat with flush=1, then with both -> no write reaches WB. A prior r4 write in MEM still reaches WB, wb_we_onehot=0x10.
6. Reset mid-op: r2 in EX, r6 in MEM, rst=1 one cycle -> next cycle all wr=0 and wb_we_onehot stays 0 in the following cycles.

Source files
------------

// File: rtl/regdst_track.sv
// Destination-register tracker: carries ID write targets through EX/MEM/WB
// and produces WB write enable, busy map and operand forwarding selects.
module regdst_track #(
  parameter int REG_W = 5,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_we,
  input  logic [REG_W-1:0] id_dest,
  input  logic             stall,
  input  logic             flush,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic [REG_W-1:0] ex_dest,
  output logic [REG_W-1:0] mem_dest,
  output logic [REG_W-1:0] wb_dest,
  output logic             ex_wr,
  output logic             mem_wr,
  output logic             wb_wr,
  output logic [NREG-1:0]  wb_we_onehot,
  output logic [NREG-1:0]  busy_vec,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b
);

  logic             ex_wr_q,    ex_wr_d;
  logic             mem_wr_q,   mem_wr_d;
  logic             wb_wr_q,    wb_wr_d;
  logic [REG_W-1:0] ex_dest_q,  ex_dest_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic [REG_W-1:0] wb_dest_q,  wb_dest_d;
  logic             accept;

  function automatic logic [NREG-1:0] dec(
    input logic             wr,
    input logic [REG_W-1:0] dest
  );
    logic [NREG-1:0] v;
    v = '0;
    if (wr) v[dest] = 1'b1;
    return v;
  endfunction

  // Youngest in-flight producer wins; r0 always reads the regfile.
  function automatic logic [1:0] sel(
    input logic [REG_W-1:0] s,
    input logic             e_wr,
    input logic [REG_W-1:0] e_dst,
    input logic             m_wr,
    input logic [REG_W-1:0] m_dst,
    input logic             w_wr,
    input logic [REG_W-1:0] w_dst
  );
    logic [1:0] r;
    r = 2'b00;
    if (s == '0)                  r = 2'b00;
    else if (e_wr && e_dst == s)  r = 2'b01;
    else if (m_wr && m_dst == s)  r = 2'b10;
    else if (w_wr && w_dst == s)  r = 2'b11;
    return r;
  endfunction

  always_comb begin
    accept = id_valid & id_we & (id_dest != '0)
           & ~stall & ~flush;
    ex_wr_d    = accept;
    ex_dest_d  = accept ? id_dest : '0;
    mem_wr_d   = ex_wr_q;
    mem_dest_d = ex_dest_q;
    wb_wr_d    = mem_wr_q;
    wb_dest_d  = mem_dest_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wr_q    <= 1'b0;
      mem_wr_q   <= 1'b0;
      wb_wr_q    <= 1'b0;
      ex_dest_q  <= '0;
      mem_dest_q <= '0;
      wb_dest_q  <= '0;
    end else begin
      ex_wr_q    <= ex_wr_d;
      mem_wr_q   <= mem_wr_d;
      wb_wr_q    <= wb_wr_d;
      ex_dest_q  <= ex_dest_d;
      mem_dest_q <= mem_dest_d;
      wb_dest_q  <= wb_dest_d;
    end
  end

  always_comb begin
    ex_dest  = ex_dest_q;
    mem_dest = mem_dest_q;
    wb_dest  = wb_dest_q;
    ex_wr    = ex_wr_q;
    mem_wr   = mem_wr_q;
    wb_wr    = wb_wr_q;
    wb_we_onehot = dec(wb_wr_q, wb_dest_q);
    busy_vec = dec(ex_wr_q, ex_dest_q)
             | dec(mem_wr_q, mem_dest_q)
             | dec(wb_wr_q, wb_dest_q);
    fwd_sel_a = sel(id_rs, ex_wr_q, ex_dest_q,
                    mem_wr_q, mem_dest_q,
                    wb_wr_q, wb_dest_q);
    fwd_sel_b = sel(id_rt, ex_wr_q, ex_dest_q,
                    mem_wr_q, mem_dest_q,
                    wb_wr_q, wb_dest_q);
  end

endmodule

// File: tb/tb_regdst_track.sv
// Bench for regdst_track: directed scenarios plus random traffic
// against a list-of-pending-writes reference model.
module tb_regdst_track;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_we = 1'b0;
  logic [4:0]  id_dest = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic        ex_wr, mem_wr, wb_wr;
  logic [31:0] wb_we_onehot, busy_vec;
  logic [1:0]  fwd_sel_a, fwd_sel_b;

  int n_tests = 0;
  int n_fail  = 0;
  // pend[k]: register being written k+1 stages past ID, 0 = none
  int pend[3] = '{0, 0, 0};

  regdst_track dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_we(id_we),
    .id_dest(id_dest), .stall(stall),
    .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .ex_dest(ex_dest), .mem_dest(mem_dest),
    .wb_dest(wb_dest), .ex_wr(ex_wr),
    .mem_wr(mem_wr), .wb_wr(wb_wr),
    .wb_we_onehot(wb_we_onehot),
    .busy_vec(busy_vec),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd(input int s);
    if (s == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (pend[k] == s) return k + 1;
    return 0;
  endfunction

  function automatic logic [31:0] busy();
    logic [31:0] b = '0;
    for (int k = 0; k < 3; k++)
      if (pend[k] != 0) b = b | (32'd1 << pend[k]);
    return b;
  endfunction

  task automatic check_model();
    logic [31:0] oh;
    oh = (pend[2] != 0) ? (32'd1 << pend[2]) : 32'd0;
    check("ex_dest",  32'(ex_dest),  32'(pend[0]));
    check("mem_dest", 32'(mem_dest), 32'(pend[1]));
    check("wb_dest",  32'(wb_dest),  32'(pend[2]));
    check("ex_wr",  32'(ex_wr),  32'(pend[0] != 0));
    check("mem_wr", 32'(mem_wr), 32'(pend[1] != 0));
    check("wb_wr",  32'(wb_wr),  32'(pend[2] != 0));
    check("onehot", wb_we_onehot, oh);
    check("busy",   busy_vec, busy());
    check("fwd_a",  32'(fwd_sel_a), 32'(fwd(int'(id_rs))));
    check("fwd_b",  32'(fwd_sel_b), 32'(fwd(int'(id_rt))));
  endtask

  task automatic step(input bit r, input bit v,
                      input bit we, input int d,
                      input bit st, input bit fl,
                      input int rs, input int rt);
    @(negedge clk);
    rst = r; id_valid = v; id_we = we;
    id_dest = 5'(d); stall = st; flush = fl;
    id_rs = 5'(rs); id_rt = 5'(rt);
    @(posedge clk);
    if (r) pend = '{0, 0, 0};
    else begin
      pend[2] = pend[1];
      pend[1] = pend[0];
      pend[0] = (v && we && !st && !fl) ? d : 0;
    end
    #1;
    check_model();
  endtask

  initial begin
    // reset with a live write presented
    step(1, 1, 1, 9, 0, 0, 9, 9);
    step(1, 1, 1, 9, 0, 0, 9, 9);
    check("rst_busy", busy_vec, 32'd0);
    check("rst_ex_wr", 32'(ex_wr), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // single write to r5 with rs=5 held
    step(0, 1, 1, 5, 0, 0, 5, 0);
    check("t2_ex_dest", 32'(ex_dest), 32'd5);
    check("t2_c1", 32'(fwd_sel_a), 32'd1);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    check("t2_c2", 32'(fwd_sel_a), 32'd2);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    check("t2_c3", 32'(fwd_sel_a), 32'd3);
    check("t2_oh", wb_we_onehot, 32'h20);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    check("t2_c4", 32'(fwd_sel_a), 32'd0);
    check("t2_busy", busy_vec, 32'd0);

    // r7 written back to back: EX copy wins
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 7, 0, 0, 0, 7);
      check("t3_fwd_b", 32'(fwd_sel_b), 32'd1);
      check("t3_busy", busy_vec, 32'h80);
    end
    step(0, 0, 0, 0, 0, 0, 0, 7);
    check("t3_mem", 32'(fwd_sel_b), 32'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // r0 is never tracked
    step(0, 1, 1, 0, 0, 0, 0, 0);
    check("t4_ex_wr", 32'(ex_wr), 32'd0);
    check("t4_fwd_a", 32'(fwd_sel_a), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_oh", wb_we_onehot, 32'd0);

    // bubbles from stall/flush; earlier r4 still retires
    step(0, 1, 1, 4, 0, 0, 0, 0);
    step(0, 1, 1, 3, 1, 0, 3, 0);
    check("t5_stall", 32'(ex_wr), 32'd0);
    step(0, 1, 1, 3, 0, 1, 3, 0);
    check("t5_flush", 32'(ex_wr), 32'd0);
    check("t5_oh", wb_we_onehot, 32'h10);
    step(0, 1, 1, 3, 1, 1, 3, 0);
    check("t5_both", 32'(ex_wr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 3, 0);
      check("t5_no_wb", wb_we_onehot, 32'd0);
    end

    // reset discards in-flight writes
    step(0, 1, 1, 6, 0, 0, 0, 0);
    step(0, 1, 1, 2, 0, 0, 0, 0);
    check("t6_pre", busy_vec, 32'h44);
    step(1, 0, 0, 0, 0, 0, 2, 6);
    check("t6_wr", 32'({ex_wr, mem_wr, wb_wr}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 2, 6);
      check("t6_oh", wb_we_onehot, 32'd0);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
